// File: rtl/lc3_wb_pkg.sv
// lc3_wb_pkg: shared constants and types for the LC3 writeback stage.
//   DATA_W/ADDR_W/NUM_REGS  datapath width, register index width, register count
//   wb_sel_t                writeback source select encoding
//   PSR_N/PSR_Z/PSR_P       bit positions of the condition codes in psr
//   lc3_word_t              one datapath word
package lc3_wb_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_PC  = 2'd1,
    WB_NPC = 2'd2,
    WB_MEM = 2'd3
  } wb_sel_t;

  localparam int PSR_N = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_P = 0;

  typedef logic [DATA_W-1:0] lc3_word_t;
endpackage

// File: rtl/lc3_regfile.sv
// lc3_regfile: NUM_REGS x DATA_W architectural register file.
//   clock, reset      rising-edge clock, async active-low reset
//   we_i/waddr_i/wdata_i   single write port
//   raddr1_i/raddr2_i -> rdata1_o/rdata2_o   two combinational read ports
// Build option: LC3_WB_FWD_EN makes a read port that addresses the register
// being written this cycle return the write data instead of the stored value.
module lc3_regfile #(
  parameter int DATA_W   = lc3_wb_pkg::DATA_W,
  parameter int NUM_REGS = lc3_wb_pkg::NUM_REGS,
  parameter int ADDR_W   = lc3_wb_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

  // One flop bank per register; each decodes its own write enable.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                    regs_q[g] <= '0;
      else if (we_i && (waddr_i == ADDR_W'(g)))      regs_q[g] <= wdata_i;
    end
  end

`ifdef LC3_WB_FWD_EN
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (we_i && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
    if (we_i && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
  end
`else
  // Read-before-write: a same-cycle write becomes visible one cycle later.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
  end
`endif

endmodule

// File: rtl/lc3_writeback.sv
// lc3_writeback: LC3 writeback stage with architectural register file.
//   clock, reset         rising-edge clock, async active-low reset
//   enable_writeback     write strobe
//   aluout_in, memout, pcout_in, npc   candidate writeback values
//   W_control            source select (0 alu, 1 pc, 2 npc, 3 mem)
//   sr1, sr2, dr         source / destination register indices
//   d1, d2               registered R[sr1], R[sr2] (1-cycle latency)
//   psr                  condition codes {N,Z,P}
// Build option: LC3_WB_FWD_EN (same-cycle write forwarding to d1/d2,
// implemented inside lc3_regfile).
module lc3_writeback #(
  parameter int DATA_W   = lc3_wb_pkg::DATA_W,
  parameter int NUM_REGS = lc3_wb_pkg::NUM_REGS,
  parameter int ADDR_W   = lc3_wb_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [DATA_W-1:0] aluout_in,
  input  logic [DATA_W-1:0] memout,
  input  logic [DATA_W-1:0] pcout_in,
  input  logic [DATA_W-1:0] npc,
  input  logic [1:0]        W_control,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [2:0]        psr
);
  import lc3_wb_pkg::*;

  logic [DATA_W-1:0] dr_in;
  logic [DATA_W-1:0] rd1, rd2;
  logic [DATA_W-1:0] d1_q, d2_q;
  logic [2:0]        psr_q, psr_d;

  // Source mux
  always_comb begin
    dr_in = aluout_in;
    case (wb_sel_t'(W_control))
      WB_ALU: dr_in = aluout_in;
      WB_PC:  dr_in = pcout_in;
      WB_NPC: dr_in = npc;
      WB_MEM: dr_in = memout;
    endcase
  end

  // Condition codes from the value being written; one-hot once written.
  always_comb begin
    psr_d = psr_q;
    if (enable_writeback) begin
      psr_d = '0;
      if (dr_in[DATA_W-1])   psr_d[PSR_N] = 1'b1;
      else if (dr_in == '0)  psr_d[PSR_Z] = 1'b1;
      else                   psr_d[PSR_P] = 1'b1;
    end
  end

  lc3_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rf (
    .clock    (clock),
    .reset    (reset),
    .we_i     (enable_writeback),
    .waddr_i  (dr),
    .wdata_i  (dr_in),
    .raddr1_i (sr1),
    .raddr2_i (sr2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // Operands are sampled every cycle regardless of the write strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d1_q  <= '0;
      d2_q  <= '0;
      psr_q <= '0;
    end else begin
      d1_q  <= rd1;
      d2_q  <= rd2;
      psr_q <= psr_d;
    end
  end

  assign d1  = d1_q;
  assign d2  = d2_q;
  assign psr = psr_q;

endmodule

// File: tb/tb_lc3_writeback.sv
module tb_lc3_writeback;
  logic        clock = 1'b0;
  logic        reset;
  logic        enable_writeback;
  logic [15:0] aluout_in, memout, pcout_in, npc;
  logic [1:0]  W_control;
  logic [2:0]  sr1, sr2, dr;
  logic [15:0] d1, d2;
  logic [2:0]  psr;

  int total = 0;
  int bad   = 0;

  lc3_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .aluout_in        (aluout_in),
    .memout           (memout),
    .pcout_in         (pcout_in),
    .npc              (npc),
    .W_control        (W_control),
    .sr1              (sr1),
    .sr2              (sr2),
    .dr               (dr),
    .d1               (d1),
    .d2               (d2),
    .psr              (psr)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable_writeback = 1'b0;
    aluout_in = '0; memout = '0; pcout_in = '0; npc = '0;
    W_control = 2'd0; sr1 = '0; sr2 = '0; dr = '0;
    cyc(); cyc();
    total++; if (d1 !== 16'h0000) begin bad++; $display("FAIL reset_d1 got=%h exp=%h", d1, 16'h0000); end
    total++; if (d2 !== 16'h0000) begin bad++; $display("FAIL reset_d2 got=%h exp=%h", d2, 16'h0000); end
    total++; if (psr !== 3'b000)  begin bad++; $display("FAIL reset_psr got=%b exp=%b", psr, 3'b000); end
    reset = 1'b1;
    // R3 = 1234, then read it back
    enable_writeback = 1'b1; dr = 3'd3; W_control = 2'd0; aluout_in = 16'h1234;
    cyc();
    enable_writeback = 1'b0; sr1 = 3'd3; sr2 = 3'd3;
    cyc();
    total++; if (d1 !== 16'h1234) begin bad++; $display("FAIL r3_read got=%h exp=%h", d1, 16'h1234); end
    total++; if (psr !== 3'b001)  begin bad++; $display("FAIL r3_psr got=%b exp=%b", psr, 3'b001); end
    // Asynchronous assertion: outputs clear without a clock edge
    #1 reset = 1'b0;
    #1;
    total++; if (d1 !== 16'h0000) begin bad++; $display("FAIL async_d1 got=%h exp=%h", d1, 16'h0000); end
    total++; if (d2 !== 16'h0000) begin bad++; $display("FAIL async_d2 got=%h exp=%h", d2, 16'h0000); end
    total++; if (psr !== 3'b000)  begin bad++; $display("FAIL async_psr got=%b exp=%b", psr, 3'b000); end
    #1 reset = 1'b1;
    cyc();
    total++; if (d1 !== 16'h0000) begin bad++; $display("FAIL r3_cleared got=%h exp=%h", d1, 16'h0000); end
  endtask

  task automatic test_sources();
    enable_writeback = 1'b1;
    dr = 3'd1; W_control = 2'd0; aluout_in = 16'h8001;
    memout = 16'h7777; pcout_in = 16'h0005; npc = 16'h0006;
    cyc();
    total++; if (psr !== 3'b100) begin bad++; $display("FAIL src_alu_psr got=%b exp=%b", psr, 3'b100); end
    dr = 3'd2; W_control = 2'd3; memout = 16'h0000; aluout_in = 16'h5555;
    cyc();
    total++; if (psr !== 3'b010) begin bad++; $display("FAIL src_mem_psr got=%b exp=%b", psr, 3'b010); end
    dr = 3'd4; W_control = 2'd2; npc = 16'h3001; pcout_in = 16'hFFFF; memout = 16'h7777;
    cyc();
    total++; if (psr !== 3'b001) begin bad++; $display("FAIL src_npc_psr got=%b exp=%b", psr, 3'b001); end
    dr = 3'd7; W_control = 2'd1; pcout_in = 16'h8ABC; npc = 16'h0001;
    cyc();
    total++; if (psr !== 3'b100) begin bad++; $display("FAIL src_pc_psr got=%b exp=%b", psr, 3'b100); end
    enable_writeback = 1'b0;
    sr1 = 3'd1; sr2 = 3'd2;
    cyc();
    total++; if (d1 !== 16'h8001) begin bad++; $display("FAIL rd_r1 got=%h exp=%h", d1, 16'h8001); end
    total++; if (d2 !== 16'h0000) begin bad++; $display("FAIL rd_r2 got=%h exp=%h", d2, 16'h0000); end
    sr1 = 3'd4; sr2 = 3'd7;
    cyc();
    total++; if (d1 !== 16'h3001) begin bad++; $display("FAIL rd_r4 got=%h exp=%h", d1, 16'h3001); end
    total++; if (d2 !== 16'h8ABC) begin bad++; $display("FAIL rd_r7 got=%h exp=%h", d2, 16'h8ABC); end
  endtask

  task automatic test_hold();
    enable_writeback = 1'b0;
    dr = 3'd1; W_control = 2'd0; aluout_in = 16'hFFFF; sr1 = 3'd1;
    cyc();
    total++; if (psr !== 3'b100)  begin bad++; $display("FAIL hold_psr got=%b exp=%b", psr, 3'b100); end
    cyc();
    total++; if (d1 !== 16'h8001) begin bad++; $display("FAIL hold_r1 got=%h exp=%h", d1, 16'h8001); end
  endtask

  task automatic test_collision();
    logic [15:0] exp_first;
`ifdef LC3_WB_FWD_EN
    exp_first = 16'h0020;
`else
    exp_first = 16'h0010;
`endif
    enable_writeback = 1'b1; dr = 3'd5; W_control = 2'd0; aluout_in = 16'h0010;
    sr1 = 3'd0; sr2 = 3'd0;
    cyc();
    aluout_in = 16'h0020; sr1 = 3'd5; sr2 = 3'd5;
    cyc();
    total++; if (d1 !== exp_first) begin bad++; $display("FAIL coll_d1 got=%h exp=%h", d1, exp_first); end
    total++; if (d2 !== exp_first) begin bad++; $display("FAIL coll_d2 got=%h exp=%h", d2, exp_first); end
    enable_writeback = 1'b0;
    cyc();
    total++; if (d1 !== 16'h0020) begin bad++; $display("FAIL coll_next_d1 got=%h exp=%h", d1, 16'h0020); end
    total++; if (d2 !== 16'h0020) begin bad++; $display("FAIL coll_next_d2 got=%h exp=%h", d2, 16'h0020); end
    total++; if (psr !== 3'b001)  begin bad++; $display("FAIL coll_psr got=%b exp=%b", psr, 3'b001); end
  endtask

  task automatic test_back_to_back();
    enable_writeback = 1'b1; W_control = 2'd0; sr1 = '0; sr2 = '0;
    for (int i = 0; i < 8; i++) begin
      dr = 3'(i); aluout_in = 16'h1000 + 16'(i);
      cyc();
    end
    enable_writeback = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      cyc();
      total++; if (d1 !== 16'h1000 + 16'(i))
        begin bad++; $display("FAIL sweep_d1[%0d] got=%h exp=%h", i, d1, 16'h1000 + 16'(i)); end
      total++; if (d2 !== 16'h1000 + 16'(7 - i))
        begin bad++; $display("FAIL sweep_d2[%0d] got=%h exp=%h", i, d2, 16'h1000 + 16'(7 - i)); end
    end
  endtask

  task automatic test_reset_mid_write();
    enable_writeback = 1'b1; W_control = 2'd0; dr = 3'd6; aluout_in = 16'h1111;
    cyc();
    aluout_in = 16'h2222;
    #2 reset = 1'b0;
    cyc();
    #2 reset = 1'b1;
    enable_writeback = 1'b0; sr1 = 3'd6; sr2 = 3'd0;
    cyc();
    total++; if (d1 !== 16'h0000) begin bad++; $display("FAIL midrst_r6 got=%h exp=%h", d1, 16'h0000); end
    total++; if (d2 !== 16'h0000) begin bad++; $display("FAIL midrst_r0 got=%h exp=%h", d2, 16'h0000); end
    total++; if (psr !== 3'b000)  begin bad++; $display("FAIL midrst_psr got=%b exp=%b", psr, 3'b000); end
  endtask

  initial begin
    test_reset();
    test_sources();
    test_hold();
    test_collision();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
